my_mod: RTL and testbench

// - Digit-stream register file with a small nibble ALU.
// - A 4-bit digit arrives every clock and is shifted into an 8-digit (32-bit) window X.
// - A[2:0] picks one digit of X. A[4:3] picks an operation against a 4-bit memory register M.
// - S latches the result onto B. I loads the picked digit into M.
// - Sits behind the lab digit-sequencer; B drives the 8-bit display/readout path.

---
 rtl/my_mod_pkg.sv | 33 +++
 rtl/my_mod_alu.sv | 44 ++++
 rtl/my_mod.sv | 74 +++++++
 tb/tb_my_mod.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/my_mod_pkg.sv
// ============================================================================
// Module      : my_mod_pkg
// Description : Shared constants, digit type and ALU opcode encoding for the
//               digit-stream register file (my_mod) and its nibble ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package my_mod_pkg;

  localparam int DW   = 4;          // digit width in bits
  localparam int NDIG = 8;          // digits held in the shift window
  localparam int XW   = DW * NDIG;  // window width in bits
  localparam int RW   = 8;          // ALU result / B width

  typedef logic [DW-1:0] digit_t;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_CAT  = 2'b10,
    OP_CMP  = 2'b11
  } op_e;

  // Pick digit 'idx' out of the window; digit 0 is the least-significant one.
  function automatic digit_t sel_digit(input logic [XW-1:0] x,
                                       input logic [2:0]    idx);
    return x[DW*idx +: DW];
  endfunction

endpackage

`default_nettype wire

// File: rtl/my_mod_alu.sv
// ============================================================================
// Module      : my_mod_alu
// Description : Purely combinational nibble ALU. Combines the selected window
//               digit with the memory register M according to the opcode.
// Ports       : nib  in  4  selected digit of the window
//               m    in  4  memory register value
//               op   in  2  operation (PASS / ADD / CAT / CMP)
//               r    out 8  result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_mod_alu
  import my_mod_pkg::*;
(
  input  digit_t        nib,
  input  digit_t        m,
  input  op_e           op,
  output logic [RW-1:0] r
);

  logic [DW:0] sum;

  // Full 5-bit sum so that F+F = 1E is reported without wrapping.
  assign sum = {1'b0, nib} + {1'b0, m};

  always_comb begin
    r = '0;
    unique case (op)
      OP_PASS: r = {4'h0, nib};
      OP_ADD:  r = {3'b000, sum};
      OP_CAT:  r = {m, nib};
      OP_CMP: begin
        if (nib > m)       r = 8'h01;
        else if (nib == m) r = 8'h00;
        else               r = 8'hFF;
      end
      default: r = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/my_mod.sv
// ============================================================================
// Module      : my_mod
// Description : Digit-stream register file. Each clock a digit is shifted
//               into an 8-digit window X; one digit of X is selected by
//               A[2:0] and combined with memory register M by the ALU
//               (opcode A[4:3]). S stores the ALU result into B, I loads the
//               selected digit into M.
// Ports       : Clk    in  1  system clock, rising edge
//               Rst_n  in  1  asynchronous active-low reset
//               Din    in  4  streamed digit
//               A      in  5  [2:0] digit index, [4:3] opcode
//               I      in  1  load enable  (M <= selected digit)
//               S      in  1  store enable (B <= ALU result)
//               B      out 8  registered result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_mod
  import my_mod_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [DW-1:0] Din,
  input  logic [4:0]    A,
  input  logic          I,
  input  logic          S,
  output logic [RW-1:0] B
);

  logic [XW-1:0] x_q, x_d;
  digit_t        m_q, m_d;
  logic [RW-1:0] b_q, b_d;

  digit_t        nib;
  logic [RW-1:0] alu_r;

  // Selection and ALU both see the pre-edge window and the old M, so the
  // digit arriving on Din this cycle is never selectable, and a combined
  // store+load computes with M before it is overwritten.
  assign nib = sel_digit(x_q, A[2:0]);

  my_mod_alu u_alu (
    .nib (nib),
    .m   (m_q),
    .op  (op_e'(A[4:3])),
    .r   (alu_r)
  );

  always_comb begin
    x_d = {x_q[XW-DW-1:0], Din};  // oldest digit drops off the top
    m_d = m_q;
    b_d = b_q;
    if (I) m_d = nib;
    if (S) b_d = alu_r;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      x_q <= '0;
      m_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      m_q <= m_d;
      b_q <= b_d;
    end
  end

  assign B = b_q;

endmodule

`default_nettype wire

// File: tb/tb_my_mod.sv
// ============================================================================
// Module      : tb_my_mod
// Description : Self-checking bench for my_mod. Stimulus pushes the expected
//               B value for each edge into a queue; a monitor pops and
//               compares one entry after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_my_mod;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] Din;
  logic [4:0] A;
  logic       I;
  logic       S;
  logic [7:0] B;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  // Reference state of the bench model
  logic [31:0] mx;
  logic [3:0]  mm;
  logic [7:0]  mb;

  my_mod dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Din   (Din),
    .A     (A),
    .I     (I),
    .S     (S),
    .B     (B)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] ref_alu(input logic [1:0] op,
                                         input logic [3:0] nib,
                                         input logic [3:0] m);
    int n, mv;
    n  = int'(nib);
    mv = int'(m);
    case (op)
      2'd0:    return 8'(n);
      2'd1:    return 8'(n + mv);
      2'd2:    return 8'(mv * 16 + n);
      default: return (n > mv) ? 8'h01 : ((n == mv) ? 8'h00 : 8'hFF);
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: B=%h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus. The model advances every call; the pushed
  // expectation is the hand value when 'hand' is set, else the model's B.
  task automatic step(input logic [3:0] din, input logic [4:0] a,
                      input logic s, input logic i, input bit hand,
                      input logic [7:0] hexp, input string tag);
    logic [3:0] nib;
    logic [7:0] r;
    @(negedge Clk);
    Din = din; A = a; S = s; I = i;
    nib = mx[4*a[2:0] +: 4];
    r   = ref_alu(a[4:3], nib, mm);
    if (s) mb = r;
    if (i) mm = nib;
    mx = {mx[27:0], din};
    exp_q.push_back(hand ? hexp : mb);
    tag_q.push_back(tag);
  endtask

  // Monitor: one comparison per rising edge that has a pending expectation.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, B, e);
      end
    end
  end

  initial begin
    logic [3:0] stream [8];
    int         wait_cnt;
    stream = '{4'h7, 4'h7, 4'h1, 4'h6, 4'h0, 4'h8, 4'h1, 4'h0};

    Rst_n = 1'b0; Din = '0; A = '0; S = 1'b0; I = 1'b0;
    mx = '0; mm = '0; mb = '0;
    #7;
    check("reset_b", B, 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Stream 7,7,1,6,0,8,1,0 -> X = 7716_0810
    foreach (stream[k]) step(stream[k], 5'b00_000, 1'b0, 1'b0, 1'b1, 8'h00, "stream_hold");

    // X=77160810: PASS idx7 with load -> B=07, M=7; X -> 71608100
    step(4'h0, 5'b00_111, 1'b1, 1'b1, 1'b1, 8'h07, "pass_load");
    // X=71608100: ADD idx6 (1) + 7 -> 08; X -> 16081000
    step(4'h0, 5'b01_110, 1'b1, 1'b0, 1'b1, 8'h08, "add_1_7");
    // X=16081000: CAT idx7 (1) with M=7 -> 71; X -> 60810009
    step(4'h9, 5'b10_111, 1'b1, 1'b0, 1'b1, 8'h71, "cat_7_1");
    // X=60810009: CMP idx5 (8) vs 7 -> 01; X -> 08100097
    step(4'h7, 5'b11_101, 1'b1, 1'b0, 1'b1, 8'h01, "cmp_gt");
    // X=08100097: CMP idx0 (7) vs 7 -> 00; X -> 81000970
    step(4'h0, 5'b11_000, 1'b1, 1'b0, 1'b1, 8'h00, "cmp_eq");
    // X=81000970: CMP idx0 (0) vs 7 -> FF; X -> 10009705
    step(4'h5, 5'b11_000, 1'b1, 1'b0, 1'b1, 8'hFF, "cmp_lt");
    // S=0 while A, I and Din toggle: B holds FF. M ends at F.
    step(4'hF, 5'b00_010, 1'b0, 1'b1, 1'b1, 8'hFF, "hold_1");  // M=7
    step(4'hF, 5'b10_001, 1'b0, 1'b0, 1'b1, 8'hFF, "hold_2");
    step(4'h3, 5'b01_000, 1'b0, 1'b1, 1'b1, 8'hFF, "hold_3");  // M=F
    // X=09705FF3: ADD idx2 (F) + F -> 1E, no wrap; X -> 9705FF32
    step(4'h2, 5'b01_010, 1'b1, 1'b0, 1'b1, 8'h1E, "add_max");
    // X=9705FF32: CAT idx6 (7) with S=I=1 uses old M=F -> F7, M becomes 7
    step(4'h0, 5'b10_110, 1'b1, 1'b1, 1'b1, 8'hF7, "si_old_m");
    // X=705FF320: CAT idx7 (7) with new M=7 -> 77
    step(4'h0, 5'b10_111, 1'b1, 1'b0, 1'b1, 8'h77, "si_new_m");

    // Asynchronous reset between edges: B clears without a clock
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_reset_b", B, 8'h00);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    mx = '0; mm = '0; mb = '0;

    // Sweep all A codes x all {S,I} against the model; early reads also
    // confirm the window and M came out of reset cleared.
    for (int a = 0; a < 32; a++) begin
      for (int si = 0; si < 4; si++) begin
        step(4'($urandom_range(0, 15)), 5'(a), si[1], si[0], 1'b0, 8'h00, "sweep");
      end
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge Clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
